// File: rtl/sequence_generate.sv
// rtl/sequence_generate.sv - serial MSB-first pattern generator with fixed zero gap and done pulse; define SEQUENCE_GENERATE_REPEAT_EN to add the repeat_frame loop input
module sequence_generate #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] length,
`ifdef SEQUENCE_GENERATE_REPEAT_EN
  input  logic             repeat_frame,
`endif
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam logic [LEN_W-1:0] WIDTH_L  = LEN_W'(WIDTH);
  localparam logic [7:0]       GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state;
  // Frame bits left-aligned so the next bit to send is always the MSB.
  logic [WIDTH-1:0] shreg;
  // Index of the bit currently on out; 0 means this is the last bit.
  logic [LEN_W-1:0] bitcnt;
  // Remaining gap cycles after the current one.
  logic [7:0]       gapcnt;

  logic [LEN_W-1:0] len_c;
  logic [WIDTH-1:0] aligned;
  logic             frame_end;

`ifdef SEQUENCE_GENERATE_REPEAT_EN
  // Copy of the accepted frame kept for replay.
  logic [WIDTH-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
`endif

  // Clamp the requested length and left-align the pattern for MSB-first shifting.
  always_comb begin
    len_c     = (length > WIDTH_L) ? WIDTH_L : length;
    aligned   = pattern << (WIDTH_L - len_c);
    frame_end = ((state == ST_SHIFT) && (bitcnt == '0) && (GAP == 0)) ||
                ((state == ST_GAP) && (gapcnt == 8'd0));
  end

  // Frame sequencer: all outputs registered, done pulses on the return to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      gapcnt <= 8'd0;
      out    <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SEQUENCE_GENERATE_REPEAT_EN
      pat_q  <= '0;
      len_q  <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (frame_end) begin
`ifdef SEQUENCE_GENERATE_REPEAT_EN
        if (repeat_frame) begin
          state  <= ST_SHIFT;
          out    <= pat_q[WIDTH-1];
          shreg  <= pat_q << 1;
          bitcnt <= len_q - LEN_W'(1);
          valid  <= 1'b1;
          busy   <= 1'b1;
          done   <= 1'b1;
        end else
`endif
        begin
          state <= ST_IDLE;
          out   <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            // A zero-length request is dropped without a done pulse.
            if (start && (length != '0)) begin
              state  <= ST_SHIFT;
              out    <= aligned[WIDTH-1];
              shreg  <= aligned << 1;
              bitcnt <= len_c - LEN_W'(1);
              valid  <= 1'b1;
              busy   <= 1'b1;
`ifdef SEQUENCE_GENERATE_REPEAT_EN
              pat_q  <= aligned;
              len_q  <= len_c;
`endif
            end
          end
          ST_SHIFT: begin
            if (bitcnt != '0) begin
              out    <= shreg[WIDTH-1];
              shreg  <= shreg << 1;
              bitcnt <= bitcnt - LEN_W'(1);
            end else begin
              // GAP > 0 here, otherwise frame_end would have caught this edge.
              state  <= ST_GAP;
              out    <= 1'b0;
              valid  <= 1'b0;
              gapcnt <= GAP_LAST;
            end
          end
          ST_GAP: begin
            gapcnt <= gapcnt - 8'd1;
          end
          default: begin
            state <= ST_IDLE;
            out   <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sequence_generate.sv
// tb/tb_sequence_generate.sv - table-driven scoreboard bench for sequence_generate
module tb_sequence_generate;

  localparam int GAP_C = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] length;
  logic       out;
  logic       valid;
  logic       busy;
  logic       done;
`ifdef SEQUENCE_GENERATE_REPEAT_EN
  logic       repeat_frame;
`endif

  int total;
  int bad;

  logic exp_q[$];
  logic sb_bit;

  typedef struct {
    logic [7:0] pat;
    logic [3:0] len;
    int         exp_len;
  } vec_t;

  vec_t vecs[7];

  sequence_generate #(.WIDTH(8), .LEN_W(4), .GAP(GAP_C)) dut (
    .clk     (clk),
    .rst     (rst_n),
    .start   (start),
    .pattern (pattern),
    .length  (length),
`ifdef SEQUENCE_GENERATE_REPEAT_EN
    .repeat_frame(repeat_frame),
`endif
    .out     (out),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every valid bit must match the next expected bit.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: got out=%0b with no expected bit queued", out);
      end else begin
        sb_bit = exp_q.pop_front();
        if (out !== sb_bit) begin
          bad++;
          $display("FAIL sb_bit: got %0b expected %0b", out, sb_bit);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input logic [7:0] pat, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(pat[i]);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_out"}, out, 0);
    chk({name, "_valid"}, valid, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
  endtask

  // Called just after the accepting edge; returns positioned in the done cycle.
  task automatic expect_frame(input int n);
    for (int i = 0; i < n; i++) begin
      chk("shift_valid", valid, 1);
      chk("shift_busy", busy, 1);
      chk("shift_done", done, 0);
      tick();
    end
    for (int g = 0; g < GAP_C; g++) begin
      chk("gap_out", out, 0);
      chk("gap_valid", valid, 0);
      chk("gap_busy", busy, 1);
      chk("gap_done", done, 0);
      tick();
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", valid, 0);
  endtask

  task automatic run_vec(input logic [7:0] pat, input logic [3:0] len, input int exp_len);
    start   = 1'b1;
    pattern = pat;
    length  = len;
    push_bits(pat, exp_len);
    tick();
    start = 1'b0;
    expect_frame(exp_len);
    tick();
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    pattern = 8'h00;
    length  = 4'd0;
`ifdef SEQUENCE_GENERATE_REPEAT_EN
    repeat_frame = 1'b0;
`endif

    vecs[0] = '{8'h0B, 4'd4,  4};
    vecs[1] = '{8'hA5, 4'd8,  8};
    vecs[2] = '{8'hFF, 4'd12, 8};
    vecs[3] = '{8'h01, 4'd1,  1};
    vecs[4] = '{8'h80, 4'd8,  8};
    vecs[5] = '{8'h59, 4'd7,  7};
    vecs[6] = '{8'h3C, 4'd15, 8};

    // Reset held for 5 cycles, with start requested to prove it is ignored.
    start  = 1'b1;
    length = 4'd4;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_quiet("reset");
    end
    start = 1'b0;
    rst_n = 1'b1;

    // Table of single frames, including length clamping.
    for (int v = 0; v < 7; v++) begin
      run_vec(vecs[v].pat, vecs[v].len, vecs[v].exp_len);
    end

    // Zero length request: no busy, no done.
    start   = 1'b1;
    pattern = 8'hFF;
    length  = 4'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_quiet("len0");
      tick();
    end

    // Back-to-back with start held high; second frame accepted in the done cycle.
    start   = 1'b1;
    pattern = 8'hA5;
    length  = 4'd8;
    push_bits(8'hA5, 8);
    tick();
    expect_frame(8);
    pattern = 8'h5A;
    length  = 4'd12;
    push_bits(8'h5A, 8);
    tick();
    start = 1'b0;
    expect_frame(8);
    tick();
    chk("b2b_done_clear", done, 0);
    chk("b2b_idle_busy", busy, 0);

    // Abort during the third bit of an 8-bit frame.
    start   = 1'b1;
    pattern = 8'hC3;
    length  = 4'd8;
    push_bits(8'hC3, 8);
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_quiet("abort_now");
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("abort_hold");
    end
    rst_n = 1'b1;
    tick();
    chk_quiet("post_abort");
    run_vec(8'h96, 4'd8, 8);

    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
